wb_arbiter_2x1: RTL and testbench
=================================

WB_ARBITER_2X1 -- requirements
Module: wb_arbiter_2x1

Interface
REQ-001 Parameter WB_ADDR_WIDTH, default 32, address width of all three ports.
REQ-002 Parameter WB_DATA_WIDTH, default 32, data width of all three ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum unacknowledged cycles before the arbiter signals an error (legal range 2..65535).
REQ-004 clk  input  1  single clock; all logic rises on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 m0  wb_if.slave  param  requester 0, e.g. instruction bus.
REQ-007 m1  wb_if.slave  param  requester 1, e.g. data bus.
REQ-008 s  wb_if.master  param  shared downstream slave/interconnect port.
REQ-009 gnt_o  output  2  one-hot current grant; 2'b00 when idle.
REQ-010 timeout_o  output  1  one-cycle pulse when a watchdog error is issued.

Function
REQ-011 A master requests when its cyc and stb are both 1.
REQ-012 FSM states: IDLE, GNT0, GNT1. Grant is registered: a request sampled in IDLE at cycle N gives GNTx in N+1, and s sees the request in N+1.
REQ-013 IDLE with exactly one requester: go to that requester's GNTx.
REQ-014 IDLE with both requesting: grant the master not granted last (round-robin); last_gnt resets to 1, so m0 wins the first contention.
REQ-015 In GNTx the grant is held while mX.cyc=1, covering bursts and stb gaps; no preemption.
REQ-016 In GNTx with mX.cyc=0: if the other master requests, go directly to its GNT state; otherwise go to IDLE. Do not regrant the same master in that cycle.
REQ-017 While in GNTx, s.cyc/stb/we/adr/dat_w/sel equal mX's signals combinationally, and mX.ack/dat_r equal s's signals combinationally. mX.err = s.err OR watchdog error.
REQ-018 In IDLE, s.cyc/stb/we are 0, adr/dat_w are 0, and sel is 0.
REQ-019 A non-granted master sees ack=0, err=0, and dat_r=0 at all times.
REQ-020 Watchdog counter (16 bit): it clears on entering any state, on s.ack, on s.err, and while s.stb=0. Otherwise it increments while s.cyc&stb=1.
REQ-021 When the counter equals TIMEOUT_CYCLES-1 without ack or err:
  - assert mX.err and timeout_o for exactly one cycle;
  - force s.stb=0 in that cycle;
  - clear the counter;
  - keep the grant.
REQ-022 If s.ack and the timeout occur in the same cycle, ack wins; no err, no timeout_o.
REQ-023 last_gnt updates on every transition into GNT0/GNT1.
REQ-024 gnt_o is 2'b01 in GNT0, 2'b10 in GNT1, and 2'b00 in IDLE.

Reset
REQ-025 rst=1 forces immediately, without waiting for a clock edge:
  - state=IDLE;
  - last_gnt=1;
  - counter=0;
  - all s outputs 0;
  - gnt_o=0 and timeout_o=0.
REQ-026 Reset asserted mid-transfer abandons the transfer. Neither master receives ack or err for it.
REQ-027 After reset deasserts, the first clock edge samples requests as in IDLE.

Structure
REQ-028 Package wb_arb_pkg holds the state enum (IDLE, GNT0, GNT1) and the watchdog counter width constant.
REQ-029 Sub-module wb_arb_watchdog holds the counter and comparison. Its ports are clk, rst, clr, run, and expire.
REQ-030 Use no other hierarchy. The top-level FSM is one registered state plus combinational muxing.

Verification
REQ-031 Single request: m0 reads 0x0000_0100 in IDLE -> gnt_o=01 next cycle, s.adr=0x0000_0100, and m0 receives s.ack/dat_r in the same cycle.
REQ-032 Contention after reset: m0 and m1 request in the same cycle -> GNT0 first. When m0 drops cyc, GNT1 follows on the next cycle with no IDLE cycle. A second contention then grants m0.
REQ-033 Burst hold: m1 holds cyc for 4 beats with a 2-cycle stb gap while m0 requests -> gnt_o stays 10 for the whole burst, and m0.ack stays 0.
REQ-034 Timeout: TIMEOUT_CYCLES=8, slave never acks m0 -> m0.err and timeout_o pulse on the 8th cycle of stb. s.stb=0 that cycle, and gnt_o stays 01.
REQ-035 Ack at timeout boundary: ack on the 8th cycle with TIMEOUT_CYCLES=8 -> m0.ack=1, m0.err=0, timeout_o=0.
REQ-036 Mid-transfer reset: rst pulses while GNT1 is active -> s.cyc=0 and gnt_o=00 immediately, with no ack or err to m1. The first contention after release grants m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int unsigned WD_CNT_W = 16;

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle; master drives the request side, slave the response side.
interface wb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    ack;
  logic                    err;
  logic [DATA_WIDTH-1:0]   dat_r;

  modport master (output cyc, stb, we, adr, dat_w, sel, input ack, err, dat_r);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output ack, err, dat_r);
endinterface

// File: rtl/wb_arb_watchdog.sv
// Counts unanswered strobe cycles and flags expiry on the TIMEOUT_CYCLES-th one.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);
  import wb_arb_pkg::*;

  localparam logic [WD_CNT_W-1:0] LIMIT = WD_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WD_CNT_W-1:0] cnt_q, cnt_d;

  assign expire = run & (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q + WD_CNT_W'(1);
    if (clr || !run || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_arbiter_2x1.sv
// Round-robin arbiter sharing one Wishbone slave between two masters, with a
// per-grant watchdog that errors out a stalled strobe.
module wb_arbiter_2x1 #(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  wb_if.slave        m0,
  wb_if.slave        m1,
  wb_if.master       s,
  output logic [1:0] gnt_o,
  output logic       timeout_o
);
  import wb_arb_pkg::*;

  localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;

  arb_state_e               state_q, state_d;
  logic                     last_gnt_q, last_gnt_d;
  logic                     req0, req1;
  logic                     mux_cyc, mux_stb, mux_we;
  logic [WB_ADDR_WIDTH-1:0] mux_adr;
  logic [WB_DATA_WIDTH-1:0] mux_dat_w;
  logic [SEL_W-1:0]         mux_sel;
  logic                     wd_clr, wd_run, wd_expire, tmo;
  logic                     is_g0, is_g1;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0:    if (!m0.cyc) state_d = req1 ? GNT1 : IDLE;
      GNT1:    if (!m1.cyc) state_d = req0 ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == GNT0) last_gnt_d = 1'b0;
      if (state_d == GNT1) last_gnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    mux_cyc   = 1'b0;
    mux_stb   = 1'b0;
    mux_we    = 1'b0;
    mux_adr   = '0;
    mux_dat_w = '0;
    mux_sel   = '0;
    unique case (state_q)
      GNT0: begin
        mux_cyc   = m0.cyc;
        mux_stb   = m0.stb;
        mux_we    = m0.we;
        mux_adr   = m0.adr;
        mux_dat_w = m0.dat_w;
        mux_sel   = m0.sel;
      end
      GNT1: begin
        mux_cyc   = m1.cyc;
        mux_stb   = m1.stb;
        mux_we    = m1.we;
        mux_adr   = m1.adr;
        mux_dat_w = m1.dat_w;
        mux_sel   = m1.sel;
      end
      default: ;
    endcase
  end

  // Watchdog runs on the master's own strobe, not the forced one, so the
  // stb kill at expiry does not feed back into its own enable.
  assign wd_run = mux_cyc & mux_stb;
  assign wd_clr = s.ack | s.err | (state_d != state_q);
  assign tmo    = wd_expire & ~s.ack & ~s.err;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr),
    .run   (wd_run),
    .expire(wd_expire)
  );

  assign s.cyc   = mux_cyc;
  assign s.stb   = mux_stb & ~wd_expire;
  assign s.we    = mux_we;
  assign s.adr   = mux_adr;
  assign s.dat_w = mux_dat_w;
  assign s.sel   = mux_sel;

  assign is_g0 = (state_q == GNT0);
  assign is_g1 = (state_q == GNT1);

  assign m0.ack   = is_g0 & s.ack;
  assign m0.err   = is_g0 & (s.err | tmo);
  assign m0.dat_r = is_g0 ? s.dat_r : '0;
  assign m1.ack   = is_g1 & s.ack;
  assign m1.err   = is_g1 & (s.err | tmo);
  assign m1.dat_r = is_g1 ? s.dat_r : '0;

  assign gnt_o     = {is_g1, is_g0};
  assign timeout_o = tmo;

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Bench for wb_arbiter_2x1: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an ownership/streak model.
module tb_wb_arbiter_2x1;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int          TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gnt;
  logic       tmo_o;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  wb_arbiter_2x1 #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .s        (s_bus),
    .gnt_o    (gnt),
    .timeout_o(tmo_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    if (k == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
      m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
      m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), who owned it last, and how
  // many consecutive strobe cycles the owner has gone unanswered.
  initial begin : model_chk
    int owner, last, streak, nxt;
    logic [1:0] cyc, stb, we, req;
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dat [2];
    logic [SW-1:0] sel [2];
    logic active, expire, e_tmo, ack, err;
    owner = -1; last = 1; streak = 0;
    forever begin
      @(negedge clk);
      if (rst) begin owner = -1; last = 1; streak = 0; end
      cyc = {m1_bus.cyc, m0_bus.cyc};
      stb = {m1_bus.stb, m0_bus.stb};
      we  = {m1_bus.we, m0_bus.we};
      req = cyc & stb;
      adr[0] = m0_bus.adr;   adr[1] = m1_bus.adr;
      dat[0] = m0_bus.dat_w; dat[1] = m1_bus.dat_w;
      sel[0] = m0_bus.sel;   sel[1] = m1_bus.sel;
      ack = s_bus.ack;
      err = s_bus.err;
      active = (owner >= 0) && req[owner];
      expire = active && (streak + 1 == TMO);
      e_tmo  = expire && !ack && !err;

      check("gnt", gnt, owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00);
      check("timeout", tmo_o, e_tmo);
      check("s_cyc", s_bus.cyc, owner >= 0 ? cyc[owner] : 1'b0);
      check("s_stb", s_bus.stb, owner >= 0 ? (stb[owner] && !expire) : 1'b0);
      check("s_we", s_bus.we, owner >= 0 ? we[owner] : 1'b0);
      check("s_adr", s_bus.adr, owner >= 0 ? adr[owner] : '0);
      check("s_dat_w", s_bus.dat_w, owner >= 0 ? dat[owner] : '0);
      check("s_sel", s_bus.sel, owner >= 0 ? sel[owner] : '0);
      check("m0_ack", m0_bus.ack, owner == 0 && ack);
      check("m0_err", m0_bus.err, owner == 0 && (err || e_tmo));
      check("m0_dat_r", m0_bus.dat_r, owner == 0 ? s_bus.dat_r : '0);
      check("m1_ack", m1_bus.ack, owner == 1 && ack);
      check("m1_err", m1_bus.err, owner == 1 && (err || e_tmo));
      check("m1_dat_r", m1_bus.dat_r, owner == 1 ? s_bus.dat_r : '0);

      nxt = owner;
      if (owner < 0) begin
        if (req[0] && req[1]) nxt = 1 - last;
        else if (req[0])      nxt = 0;
        else if (req[1])      nxt = 1;
      end else if (!cyc[owner]) begin
        nxt = req[1 - owner] ? 1 - owner : -1;
      end

      @(posedge clk);
      if (rst) begin
        owner = -1; last = 1; streak = 0;
      end else begin
        if (nxt != owner) streak = 0;
        else if (active && !ack && !err && !expire) streak = streak + 1;
        else streak = 0;
        if (nxt >= 0 && nxt != owner) last = nxt;
        owner = nxt;
      end
    end
  end

  initial begin : stim
    logic [1:0] rc;
    int ack_pct, err_pct;
    logic [5:0] burst;
    drive(0, 0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, 0, '0, '0, '0);
    s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.dat_r = '0;
    #2;
    check("rst_gnt", gnt, 2'b00);
    check("rst_s_cyc", s_bus.cyc, 1'b0);
    check("rst_tmo", tmo_o, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // single read by m0
    drive(0, 1, 1, 0, 32'h0000_0100, '0, 4'hF);
    #1 check("single_idle_gnt", gnt, 2'b00);
    tick();
    s_bus.ack = 1'b1; s_bus.dat_r = 32'hCAFE_0001;
    #1;
    check("single_gnt", gnt, 2'b01);
    check("single_adr", s_bus.adr, 32'h0000_0100);
    check("single_ack", m0_bus.ack, 1'b1);
    check("single_dat", m0_bus.dat_r, 32'hCAFE_0001);
    tick();
    drive(0, 0, 0, 0, '0, '0, '0);
    s_bus.ack = 1'b0;
    tick();
    #1 check("single_back_idle", gnt, 2'b00);

    // m1 wins contention (m0 was last), holds through an stb gap
    drive(0, 1, 1, 1, 32'h0000_0200, 32'h1111_2222, 4'h3);
    drive(1, 1, 1, 0, 32'h0000_0300, '0, 4'hF);
    tick();
    burst = 6'b110011;
    for (int i = 0; i < 6; i++) begin
      m1_bus.stb = burst[5 - i];
      s_bus.ack  = burst[5 - i];
      #1;
      check("burst_gnt", gnt, 2'b10);
      check("burst_m0_ack", m0_bus.ack, 1'b0);
      tick();
    end
    drive(1, 0, 0, 0, '0, '0, '0);
    s_bus.ack = 1'b0;
    #1 check("burst_end_gnt", gnt, 2'b10);
    tick();
    #1 check("handover_gnt", gnt, 2'b01);

    // m0 stalls: timeout on 8th strobe cycle
    for (int i = 1; i <= TMO; i++) begin
      if (i > 1) tick();
      #1 check("wd_pulse", tmo_o, i == TMO);
      if (i == TMO) begin
        check("wd_err", m0_bus.err, 1'b1);
        check("wd_stb", s_bus.stb, 1'b0);
        check("wd_gnt", gnt, 2'b01);
      end
    end

    // ack lands exactly on the expiry cycle
    for (int i = 1; i <= TMO; i++) begin
      tick();
      if (i == TMO) s_bus.ack = 1'b1;
      #1;
    end
    check("edge_ack", m0_bus.ack, 1'b1);
    check("edge_err", m0_bus.err, 1'b0);
    check("edge_tmo", tmo_o, 1'b0);
    tick();
    s_bus.ack = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0);

    // reset during m1 ownership
    tick();
    drive(1, 1, 1, 0, 32'h0000_0400, '0, 4'hF);
    tick();
    #1 check("pre_rst_gnt", gnt, 2'b10);
    rst = 1'b1; s_bus.ack = 1'b1; s_bus.err = 1'b1;
    #1;
    check("rst_mid_cyc", s_bus.cyc, 1'b0);
    check("rst_mid_gnt", gnt, 2'b00);
    check("rst_mid_ack", m1_bus.ack, 1'b0);
    check("rst_mid_err", m1_bus.err, 1'b0);
    tick(); tick();
    rst = 1'b0; s_bus.ack = 1'b0; s_bus.err = 1'b0;
    drive(0, 1, 1, 0, 32'h0000_0500, '0, 4'hF);
    tick();
    #1 check("post_rst_first", gnt, 2'b01);
    drive(0, 0, 0, 0, '0, '0, '0);
    tick();
    #1 check("no_idle_handover", gnt, 2'b10);
    drive(1, 0, 0, 0, '0, '0, '0);
    tick();
    #1 check("idle_between", gnt, 2'b00);
    drive(0, 1, 1, 0, 32'h0000_0600, '0, 4'hF);
    drive(1, 1, 1, 0, 32'h0000_0700, '0, 4'hF);
    tick();
    #1 check("second_contention", gnt, 2'b01);
    drive(0, 0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, 0, '0, '0, '0);
    tick();

    // random traffic
    rc = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      tick();
      ack_pct = ((c / 250) % 3 == 0) ? 0 : ((c / 250) % 3 == 1) ? 10 : 50;
      err_pct = ((c / 250) % 3 == 1) ? 3 : 0;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 99) < 12) rc[k] = ~rc[k];
        drive(k, rc[k],
              rc[k] ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 10),
              1'($urandom), $urandom, $urandom, 4'($urandom));
      end
      s_bus.ack   = ($urandom_range(0, 99) < ack_pct);
      s_bus.err   = ($urandom_range(0, 99) < err_pct);
      s_bus.dat_r = $urandom;
      rst         = ($urandom_range(0, 499) == 0);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
